hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage core. It produces the freeze, bubble and flush controls that the forwarding path cannot cover: load-use stalls, data-memory wait states with a timeout, and taken-branch squashes. It sits beside the forwarding unit and drives the enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal values 1 or 2.
- MEM_TIMEOUT, 255: maximum consecutive wait cycles on the data memory; legal range 1–255.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- source1_DECODE, source2_DECODE, store_DECODE  in  5 each  register operands of the instruction in ID
- destination_EXECUTE  in  5  destination register of the instruction in EX
- writeback_EXECUTE  in  1  EX instruction writes a register
- memread_EXECUTE  in  1  EX instruction is a load
- branch_taken_EXECUTE  in  1  taken branch/jump resolved in EX
- mem_req_MEMORY  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- freeze_IF, freeze_DECODE  out  1 each  hold PC and IF/ID
- freeze_EXECUTE, freeze_MEMORY  out  1 each  hold ID/EX and EX/MEM
- bubble_EXECUTE  out  1  load a NOP into ID/EX
- bubble_WRITEBACK  out  1  load a NOP into MEM/WB (writeback disabled)
- flush_IF_DECODE  out  1  squash IF and IF/ID contents
- mem_timeout  out  1  sticky timeout flag

## Operation
- load_use = memread_EXECUTE & writeback_EXECUTE & destination_EXECUTE != 0 & (destination_EXECUTE equals any of the three DECODE operands). R0 never causes a hazard.
- mem_wait = mem_req_MEMORY & ~mem_ready.
- Priority within a cycle: mem_wait > branch_taken_EXECUTE > load_use.
- FSM states: RUN, LOAD_STALL, MEM_WAIT.
- RUN
  - mem_wait: assert all four freezes and bubble_WRITEBACK; clear wait_cnt to 1; go to MEM_WAIT.
  - Otherwise, branch_taken_EXECUTE: assert flush_IF_DECODE and bubble_EXECUTE; stay in RUN. A coincident load_use is ignored because the dependent instruction is squashed.
  - Otherwise, load_use: assert freeze_IF, freeze_DECODE and bubble_EXECUTE. Go to LOAD_STALL if LOAD_STALL_CYCLES == 2; otherwise stay in RUN.
- LOAD_STALL
  - Assert freeze_IF, freeze_DECODE and bubble_EXECUTE, then go to RUN.
  - If mem_wait is high, handle it as in RUN instead. The pending second bubble is dropped; load_use is re-evaluated after release.
- MEM_WAIT
  - While mem_wait holds: keep all freezes and bubble_WRITEBACK asserted and increment wait_cnt (8-bit).
  - mem_ready high: no outputs asserted that cycle (the access completes); go to RUN.
  - wait_cnt == MEM_TIMEOUT with mem_ready still low: set mem_timeout; assert bubble_WRITEBACK only, so the access result is dropped and the pipeline advances; go to RUN.
- Outputs are Mealy: a function of the current state and the current inputs, effective in the same cycle.

## Timing
- rst high: next state RUN; wait_cnt, mem_timeout and the stats counters cleared. All outputs are forced to 0 while rst is high.
- Reset mid-MEM_WAIT or mid-LOAD_STALL: the block is in RUN the following cycle with no residual stall.
- Load-use latency: 0 cycles to the first bubble. The total is exactly LOAD_STALL_CYCLES bubbles when no memory wait intervenes.
- Memory wait: freeze asserted in the first wait cycle, released in the mem_ready cycle. The maximum freeze length is MEM_TIMEOUT cycles.
- mem_timeout stays at 1 until rst.
- A repeated timeout while mem_timeout is already set behaves identically.

## Configuration
- HAZARD_STATS_EN defined: adds three 32-bit wrapping outputs, all cleared by rst:
  - stat_load_stalls: increments on every cycle bubble_EXECUTE is asserted due to load_use or LOAD_STALL.
  - stat_mem_waits: increments on every cycle in which freeze_MEMORY is asserted.
  - stat_flushes: increments on every cycle flush_IF_DECODE is asserted.
- HAZARD_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared pipeline package holds:
  - state encodings: RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2
  - REG_ZERO=5'd0
  - register-index width 5
- One sub-module, hazard_mem_timer:
  - contains the 8-bit wait_cnt, the timeout compare and the sticky mem_timeout flag
  - takes start/run/done strobes from the FSM
- The FSM and hazard decode stay in hazard_unit.

## Test plan
- Load to r5 in EX, source2_DECODE=5, LOAD_STALL_CYCLES=1 -> one cycle with freeze_IF=freeze_DECODE=bubble_EXECUTE=1, then all 0.
- Same hazard with LOAD_STALL_CYCLES=2 -> exactly two bubble cycles. A repeat with destination_EXECUTE=0 gives no stall.
- Load-use and branch_taken_EXECUTE in the same cycle -> flush_IF_DECODE=1, bubble_EXECUTE=1, freeze_IF=0, no second cycle.
- mem_req_MEMORY=1 with mem_ready low for 3 cycles, then high -> freezes and bubble_WRITEBACK high for 3 cycles, 0 in the ready cycle, state RUN.
- MEM_TIMEOUT=4, mem_ready never high -> 4 freeze cycles, mem_timeout=1 after that, pipeline released. rst pulse -> mem_timeout=0.
- With HAZARD_STATS_EN, run the above sequence -> stat_load_stalls=3, stat_mem_waits=7, stat_flushes=1. rst mid-MEM_WAIT clears all counters.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared definitions for the pipeline hazard controller.
//   REG_IDX_W      : register-index width
//   REG_ZERO       : hard-wired zero register, never a hazard source
//   hazard_state_e : hazard FSM state encoding
package hazard_unit_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2
    } hazard_state_e;

    // True when a non-zero EX destination feeds any of the three ID operands.
    function automatic logic dest_hits_operand(input reg_idx_t dest, input reg_idx_t src1,
                                               input reg_idx_t src2, input reg_idx_t store);
        return (dest != REG_ZERO) && ((dest == src1) || (dest == src2) || (dest == store));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives operand/status signals, receives stall controls
//   slave  : hazard unit side
// Signals: source1/2_DECODE, store_DECODE, destination_EXECUTE, writeback_EXECUTE,
// memread_EXECUTE, branch_taken_EXECUTE, mem_req_MEMORY, mem_ready (to the unit);
// freeze_IF/DECODE/EXECUTE/MEMORY, bubble_EXECUTE, bubble_WRITEBACK,
// flush_IF_DECODE, mem_timeout (from the unit).
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    reg_idx_t source1_DECODE;
    reg_idx_t source2_DECODE;
    reg_idx_t store_DECODE;
    reg_idx_t destination_EXECUTE;
    logic     writeback_EXECUTE;
    logic     memread_EXECUTE;
    logic     branch_taken_EXECUTE;
    logic     mem_req_MEMORY;
    logic     mem_ready;

    logic     freeze_IF;
    logic     freeze_DECODE;
    logic     freeze_EXECUTE;
    logic     freeze_MEMORY;
    logic     bubble_EXECUTE;
    logic     bubble_WRITEBACK;
    logic     flush_IF_DECODE;
    logic     mem_timeout;

    modport master (
        output source1_DECODE, source2_DECODE, store_DECODE, destination_EXECUTE,
        output writeback_EXECUTE, memread_EXECUTE, branch_taken_EXECUTE,
        output mem_req_MEMORY, mem_ready,
        input  freeze_IF, freeze_DECODE, freeze_EXECUTE, freeze_MEMORY,
        input  bubble_EXECUTE, bubble_WRITEBACK, flush_IF_DECODE, mem_timeout
    );

    modport slave (
        input  source1_DECODE, source2_DECODE, store_DECODE, destination_EXECUTE,
        input  writeback_EXECUTE, memread_EXECUTE, branch_taken_EXECUTE,
        input  mem_req_MEMORY, mem_ready,
        output freeze_IF, freeze_DECODE, freeze_EXECUTE, freeze_MEMORY,
        output bubble_EXECUTE, bubble_WRITEBACK, flush_IF_DECODE, mem_timeout
    );

endinterface

// File: rtl/hazard_mem_timer.sv
// hazard_mem_timer: data-memory wait counter with sticky timeout flag.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : first wait cycle, counter loads 1
//   i_run            : further wait cycle, counter increments
//   i_done           : timeout taken, sets the sticky flag
//   o_expired        : counter has reached MEM_TIMEOUT
//   o_mem_timeout    : sticky timeout flag, cleared only by reset
module hazard_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_run,
    input  logic i_done,
    output logic o_expired,
    output logic o_mem_timeout
);

    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (i_start) begin
                r_wait_cnt <= 8'd1;
            end else if (i_run) begin
                // Cannot wrap: the FSM leaves the wait state at MEM_TIMEOUT <= 255.
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (i_done) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign o_expired     = (r_wait_cnt == 8'(MEM_TIMEOUT));
    assign o_mem_timeout = r_mem_timeout;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall, memory wait/timeout and branch squash controller.
//   i_clk, i_rst : clock, synchronous active-high reset (forces all outputs low)
//   bus          : hazard_unit_if.slave, pipeline operands/status in, stall controls out
//   o_stat_*     : 32-bit wrapping event counters, present only with HAZARD_STATS_EN
// Parameters: LOAD_STALL_CYCLES (1 or 2), MEM_TIMEOUT (1..255).
// Outputs are Mealy: decoded from the current state and current inputs.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    hazard_unit_if.slave  bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   o_stat_load_stalls,
    output logic [31:0]   o_stat_mem_waits,
    output logic [31:0]   o_stat_flushes
`endif
);

    hazard_state_e r_state;
    hazard_state_e w_state_next;

    logic w_load_use;
    logic w_mem_wait;
    logic w_freeze_front;   // freeze_IF / freeze_DECODE
    logic w_freeze_back;    // freeze_EXECUTE / freeze_MEMORY
    logic w_bubble_ex;
    logic w_bubble_wb;
    logic w_flush;
    logic w_ls_bubble;      // bubble caused by a load-use, not by a branch
    logic w_tmr_start;
    logic w_tmr_run;
    logic w_tmr_done;
    logic w_tmr_expired;
    logic w_timeout_flag;

    assign w_load_use = bus.memread_EXECUTE & bus.writeback_EXECUTE &
                        dest_hits_operand(bus.destination_EXECUTE, bus.source1_DECODE,
                                          bus.source2_DECODE, bus.store_DECODE);
    assign w_mem_wait = bus.mem_req_MEMORY & ~bus.mem_ready;

    always_comb begin
        w_state_next   = r_state;
        w_freeze_front = 1'b0;
        w_freeze_back  = 1'b0;
        w_bubble_ex    = 1'b0;
        w_bubble_wb    = 1'b0;
        w_flush        = 1'b0;
        w_ls_bubble    = 1'b0;
        w_tmr_start    = 1'b0;
        w_tmr_run      = 1'b0;
        w_tmr_done     = 1'b0;
        if (i_rst) begin
            w_state_next = StRun;
        end else begin
            case (r_state)
                StRun, StLoadStall: begin
                    if (w_mem_wait) begin
                        // A pending second load bubble is dropped here.
                        w_freeze_front = 1'b1;
                        w_freeze_back  = 1'b1;
                        w_bubble_wb    = 1'b1;
                        w_tmr_start    = 1'b1;
                        w_state_next   = StMemWait;
                    end else if (r_state == StLoadStall) begin
                        w_freeze_front = 1'b1;
                        w_bubble_ex    = 1'b1;
                        w_ls_bubble    = 1'b1;
                        w_state_next   = StRun;
                    end else if (bus.branch_taken_EXECUTE) begin
                        // Dependent ID instruction is squashed, so load-use is moot.
                        w_flush     = 1'b1;
                        w_bubble_ex = 1'b1;
                    end else if (w_load_use) begin
                        w_freeze_front = 1'b1;
                        w_bubble_ex    = 1'b1;
                        w_ls_bubble    = 1'b1;
                        w_state_next   = (LOAD_STALL_CYCLES == 2) ? StLoadStall : StRun;
                    end
                end
                StMemWait: begin
                    if (!w_mem_wait) begin
                        w_state_next = StRun;
                    end else if (w_tmr_expired) begin
                        // Drop the access result and let the pipeline advance.
                        w_bubble_wb  = 1'b1;
                        w_tmr_done   = 1'b1;
                        w_state_next = StRun;
                    end else begin
                        w_freeze_front = 1'b1;
                        w_freeze_back  = 1'b1;
                        w_bubble_wb    = 1'b1;
                        w_tmr_run      = 1'b1;
                    end
                end
                default: w_state_next = StRun;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    hazard_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (w_tmr_start),
        .i_run         (w_tmr_run),
        .i_done        (w_tmr_done),
        .o_expired     (w_tmr_expired),
        .o_mem_timeout (w_timeout_flag)
    );

    assign bus.freeze_IF        = w_freeze_front;
    assign bus.freeze_DECODE    = w_freeze_front;
    assign bus.freeze_EXECUTE   = w_freeze_back;
    assign bus.freeze_MEMORY    = w_freeze_back;
    assign bus.bubble_EXECUTE   = w_bubble_ex;
    assign bus.bubble_WRITEBACK = w_bubble_wb;
    assign bus.flush_IF_DECODE  = w_flush;
    assign bus.mem_timeout      = w_timeout_flag & ~i_rst;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stat_load_stalls;
    logic [31:0] r_stat_mem_waits;
    logic [31:0] r_stat_flushes;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_load_stalls <= 32'd0;
            r_stat_mem_waits   <= 32'd0;
            r_stat_flushes     <= 32'd0;
        end else begin
            r_stat_load_stalls <= r_stat_load_stalls + 32'(w_ls_bubble);
            r_stat_mem_waits   <= r_stat_mem_waits + 32'(w_freeze_back);
            r_stat_flushes     <= r_stat_flushes + 32'(w_flush);
        end
    end

    assign o_stat_load_stalls = i_rst ? 32'd0 : r_stat_load_stalls;
    assign o_stat_mem_waits   = i_rst ? 32'd0 : r_stat_mem_waits;
    assign o_stat_flushes     = i_rst ? 32'd0 : r_stat_flushes;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed bench for hazard_unit.
// Two instances share one stimulus: u_dut1 (LOAD_STALL_CYCLES=1, MEM_TIMEOUT=4) and
// u_dut2 (LOAD_STALL_CYCLES=2, MEM_TIMEOUT=255). Inputs change 1 time unit after the
// rising edge; outputs are compared on the falling edge.
// Output vector bits: [7]freeze_IF [6]freeze_DECODE [5]freeze_EXECUTE [4]freeze_MEMORY
// [3]bubble_EXECUTE [2]bubble_WRITEBACK [1]flush_IF_DECODE [0]mem_timeout.
module tb_hazard_unit;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_BR   = 8'b0000_1010;
    localparam logic [7:0] O_MW   = 8'b1111_0100;
    localparam logic [7:0] O_TO   = 8'b0000_0100;
    localparam logic [7:0] O_STK  = 8'b0000_0001;

    typedef struct {
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] st;
        logic [4:0] dst;
        logic       wb;
        logic       mr;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] r_s1, r_s2, r_st, r_dst;
    logic       r_wb, r_mr, r_br, r_req, r_rdy;
    int         n_total = 0;
    int         n_bad   = 0;
    vec_t       tbl[13];

    always #5 clk = ~clk;

    hazard_unit_if if1 ();
    hazard_unit_if if2 ();

    assign if1.source1_DECODE       = r_s1;
    assign if1.source2_DECODE       = r_s2;
    assign if1.store_DECODE         = r_st;
    assign if1.destination_EXECUTE  = r_dst;
    assign if1.writeback_EXECUTE    = r_wb;
    assign if1.memread_EXECUTE      = r_mr;
    assign if1.branch_taken_EXECUTE = r_br;
    assign if1.mem_req_MEMORY       = r_req;
    assign if1.mem_ready            = r_rdy;
    assign if2.source1_DECODE       = r_s1;
    assign if2.source2_DECODE       = r_s2;
    assign if2.store_DECODE         = r_st;
    assign if2.destination_EXECUTE  = r_dst;
    assign if2.writeback_EXECUTE    = r_wb;
    assign if2.memread_EXECUTE      = r_mr;
    assign if2.branch_taken_EXECUTE = r_br;
    assign if2.mem_req_MEMORY       = r_req;
    assign if2.mem_ready            = r_rdy;

    logic [7:0] w_out1, w_out2;
    assign w_out1 = {if1.freeze_IF, if1.freeze_DECODE, if1.freeze_EXECUTE, if1.freeze_MEMORY,
                     if1.bubble_EXECUTE, if1.bubble_WRITEBACK, if1.flush_IF_DECODE,
                     if1.mem_timeout};
    assign w_out2 = {if2.freeze_IF, if2.freeze_DECODE, if2.freeze_EXECUTE, if2.freeze_MEMORY,
                     if2.bubble_EXECUTE, if2.bubble_WRITEBACK, if2.flush_IF_DECODE,
                     if2.mem_timeout};

`ifdef HAZARD_STATS_EN
    logic [31:0] st1_ls, st1_mw, st1_fl, st2_ls, st2_mw, st2_fl;
`endif

    hazard_unit #(
        .LOAD_STALL_CYCLES (1),
        .MEM_TIMEOUT       (4)
    ) u_dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if1.slave)
`ifdef HAZARD_STATS_EN
        ,
        .o_stat_load_stalls (st1_ls),
        .o_stat_mem_waits   (st1_mw),
        .o_stat_flushes     (st1_fl)
`endif
    );

    hazard_unit #(
        .LOAD_STALL_CYCLES (2),
        .MEM_TIMEOUT       (255)
    ) u_dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if2.slave)
`ifdef HAZARD_STATS_EN
        ,
        .o_stat_load_stalls (st2_ls),
        .o_stat_mem_waits   (st2_mw),
        .o_stat_flushes     (st2_fl)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] st,
                         input logic [4:0] dst, input logic wb, input logic mr,
                         input logic br, input logic req, input logic rdy);
        r_s1 = s1; r_s2 = s2; r_st = st; r_dst = dst;
        r_wb = wb; r_mr = mr; r_br = br; r_req = req; r_rdy = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load to r5 in EX, consumer reads r5 on source2.
    task automatic load_use(input logic br);
        drive(5'd1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, br, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        //            s1     s2     st     dst    wb    mr    br    req   rdy   expected
        tbl[0]  = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[1]  = '{5'd1,  5'd5,  5'd2,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[2]  = '{5'd5,  5'd3,  5'd2,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[3]  = '{5'd1,  5'd3,  5'd5,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
        tbl[4]  = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[5]  = '{5'd5,  5'd5,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[6]  = '{5'd5,  5'd5,  5'd5,  5'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[7]  = '{5'd6,  5'd5,  5'd4,  5'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE};
        tbl[8]  = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
        tbl[9]  = '{5'd1,  5'd5,  5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
        tbl[10] = '{5'd1,  5'd5,  5'd2,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};
        tbl[11] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE};
        tbl[12] = '{5'd3,  5'd31, 5'd2,  5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};

        // Outputs forced low while reset is high, even with hazards present.
        rst = 1'b1;
        drive(5'd1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        check("rst_out1", 32'(w_out1), 32'(O_NONE));
        check("rst_out2", 32'(w_out2), 32'(O_NONE));
        tick();
        do_reset();

        // Single-cycle decode table on the LOAD_STALL_CYCLES=1 instance.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].s1, tbl[i].s2, tbl[i].st, tbl[i].dst, tbl[i].wb, tbl[i].mr,
                  tbl[i].br, tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(w_out1), 32'(tbl[i].exp));
            tick();
        end

        // LOAD_STALL_CYCLES=1: one bubble, then clear.
        do_reset();
        load_use(1'b0);
        @(negedge clk); check("ls1_first", 32'(w_out1), 32'(O_LU));
        tick(); idle();
        @(negedge clk); check("ls1_after", 32'(w_out1), 32'(O_NONE));
        tick();

        // LOAD_STALL_CYCLES=2: exactly two bubbles; r0 destination never stalls.
        do_reset();
        load_use(1'b0);
        @(negedge clk); check("ls2_first", 32'(w_out2), 32'(O_LU));
        tick(); idle();
        @(negedge clk); check("ls2_second", 32'(w_out2), 32'(O_LU));
        tick();
        @(negedge clk); check("ls2_done", 32'(w_out2), 32'(O_NONE));
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); check("ls2_r0", 32'(w_out2), 32'(O_NONE));
        tick(); idle();
        @(negedge clk); check("ls2_r0_next", 32'(w_out2), 32'(O_NONE));
        tick();

        // Branch beats load-use; no second bubble afterwards.
        load_use(1'b1);
        @(negedge clk); check("br_lu", 32'(w_out2), 32'(O_BR));
        tick(); idle();
        @(negedge clk); check("br_lu_next", 32'(w_out2), 32'(O_NONE));
        tick();

        // Memory wait 3 cycles, then ready; back in RUN afterwards.
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check($sformatf("mw_wait%0d", i), 32'(w_out1), 32'(O_MW));
            tick();
        end
        r_rdy = 1'b1;
        @(negedge clk); check("mw_ready", 32'(w_out1), 32'(O_NONE));
        tick();
        load_use(1'b0);
        @(negedge clk); check("mw_run", 32'(w_out1), 32'(O_LU));
        tick();

        // Timeout at MEM_TIMEOUT=4, sticky flag, identical repeat, cleared by reset.
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check($sformatf("to%0d_wait%0d", rep, i), 32'(w_out1),
                      32'(rep == 0 ? O_MW : (O_MW | O_STK)));
                tick();
            end
            @(negedge clk);
            check($sformatf("to%0d_release", rep), 32'(w_out1),
                  32'(rep == 0 ? O_TO : (O_TO | O_STK)));
            tick(); idle();
            @(negedge clk); check($sformatf("to%0d_sticky", rep), 32'(w_out1), 32'(O_STK));
            tick();
        end
        rst = 1'b1;
        @(negedge clk); check("to_rst_forced", 32'(w_out1), 32'(O_NONE));
        tick(); rst = 1'b0;
        @(negedge clk); check("to_cleared", 32'(w_out1), 32'(O_NONE));
        tick();

        // Memory wait pre-empts the pending second load bubble.
        do_reset();
        load_use(1'b0);
        @(negedge clk); check("lsmw_first", 32'(w_out2), 32'(O_LU));
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); check("lsmw_wait", 32'(w_out2), 32'(O_MW));
        tick(); r_rdy = 1'b1;
        @(negedge clk); check("lsmw_ready", 32'(w_out2), 32'(O_NONE));
        tick(); idle();
        @(negedge clk); check("lsmw_dropped", 32'(w_out2), 32'(O_NONE));
        tick();

        // Reset mid-MEM_WAIT: RUN next cycle, a branch is handled normally.
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); check("rst_memwait", 32'(w_out1), 32'(O_BR));
        tick();

        // Reset mid-LOAD_STALL: no residual bubble.
        do_reset();
        load_use(1'b0);
        tick();
        rst = 1'b1; idle();
        tick(); rst = 1'b0;
        @(negedge clk); check("rst_loadstall", 32'(w_out2), 32'(O_NONE));
        tick();

`ifdef HAZARD_STATS_EN
        // Same stimulus into both instances; counts differ by configuration.
        do_reset();
        load_use(1'b0);
        tick(); idle();
        tick(); load_use(1'b1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        r_rdy = 1'b1;
        tick(); r_rdy = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        idle();
        tick();
        @(negedge clk);
        check("st1_load", st1_ls, 32'd1);
        check("st1_memw", st1_mw, 32'd7);
        check("st1_flush", st1_fl, 32'd1);
        check("st2_load", st2_ls, 32'd2);
        check("st2_memw", st2_mw, 32'd8);
        check("st2_flush", st2_fl, 32'd1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0; idle();
        @(negedge clk);
        check("st_rst_memw", st1_mw, 32'd0);
        check("st_rst_load", st2_ls, 32'd0);
        check("st_rst_flush", st1_fl, 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
